// File: rtl/branch_unit.sv
// branch_unit
// Registered branch-resolution unit for the execute stage. It checks the Thumb
// condition code against the NZCV flags and resolves an immediate (PC-relative)
// or register (BX/BLX) target. A taken branch produces a one-cycle PC-load
// strobe, and an LR-write strobe when linking. It then holds a counted flush
// window, and new requests arriving during that window are dropped.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   br_valid        request strobe, accepted only while busy is low
//   br_type         00 B, 01 conditional B, 10 BX register, 11 reserved
//   link            write LR when the branch is taken
//   cond, nzcv      condition code (type 01 only) and flags {N,Z,C,V}
//   offset, in_PC   PC-relative target operands (types 00/01)
//   target          register target for type 10 (bit0 = Thumb bit, dropped)
//   pc_load, out_PC one-cycle strobe with the resolved target (0 otherwise)
//   lr_we, LR       one-cycle strobe with the return address (0 otherwise)
//   flush, busy     high throughout the flush window
//   bad_type        one-cycle strobe when a type 11 request is accepted
module branch_unit #(
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic              link,
  input  logic [3:0]        cond,
  input  logic [3:0]        nzcv,
  input  logic [DATA_W-1:0] offset,
  input  logic [DATA_W-1:0] in_PC,
  input  logic [DATA_W-1:0] target,
  output logic              pc_load,
  output logic [DATA_W-1:0] out_PC,
  output logic              lr_we,
  output logic [DATA_W-1:0] LR,
  output logic              flush,
  output logic              busy,
  output logic              bad_type
);

  typedef enum logic {
    StIdle,
    StFlush
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pcLoad_q, pcLoad_d;
  logic [DATA_W-1:0] outPc_q, outPc_d;
  logic              lrWe_q, lrWe_d;
  logic [DATA_W-1:0] lr_q, lr_d;
  logic              badType_q, badType_d;

  logic              accept;
  logic              condBase;
  logic              condHit;
  logic              taken;
  logic [DATA_W-1:0] resolvedTarget;

  assign accept = br_valid && (state_q == StIdle);

  // Condition codes come in pairs: the even code tests a base predicate and
  // the odd code is its inverse. This includes 1110/1111 (always/never).
  always_comb begin
    condBase = 1'b1;
    unique case (cond[3:1])
      3'b000:  condBase = nzcv[2];
      3'b001:  condBase = nzcv[1];
      3'b010:  condBase = nzcv[3];
      3'b011:  condBase = nzcv[0];
      3'b100:  condBase = nzcv[1] & ~nzcv[2];
      3'b101:  condBase = (nzcv[3] == nzcv[0]);
      3'b110:  condBase = ~nzcv[2] & (nzcv[3] == nzcv[0]);
      default: condBase = 1'b1;
    endcase
    condHit = condBase ^ cond[0];
  end

  // Types 00 and 10 are unconditional. Type 11 never takes the branch.
  assign taken = accept && (br_type != 2'b11) && ((br_type != 2'b01) || condHit);

  assign resolvedTarget = (br_type == 2'b10) ? (target & ~DATA_W'(1))
                                             : (in_PC + offset);

  // Next-state logic for the flush window, plus the result registers.
  // The count is loaded so that the window lasts exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcLoad_d  = taken;
    outPc_d   = taken ? resolvedTarget : '0;
    lrWe_d    = taken && link;
    lr_d      = (taken && link) ? (in_PC | DATA_W'(1)) : '0;
    badType_d = accept && (br_type == 2'b11);

    if (state_q == StIdle) begin
      if (taken) begin
        state_d = StFlush;
        cnt_d   = 4'(FLUSH_CYCLES - 1);
      end
    end else begin
      if (cnt_q == 4'd0) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // State and result registers. Reset takes priority over any request in
  // the same cycle and abandons an open flush window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pcLoad_q  <= 1'b0;
      outPc_q   <= '0;
      lrWe_q    <= 1'b0;
      lr_q      <= '0;
      badType_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcLoad_q  <= pcLoad_d;
      outPc_q   <= outPc_d;
      lrWe_q    <= lrWe_d;
      lr_q      <= lr_d;
      badType_q <= badType_d;
    end
  end

  assign pc_load  = pcLoad_q;
  assign out_PC   = outPc_q;
  assign lr_we    = lrWe_q;
  assign LR       = lr_q;
  assign flush    = (state_q == StFlush);
  assign busy     = (state_q == StFlush);
  assign bad_type = badType_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

Registered branch-resolution unit for the Cortex-M0 execute stage. It generalises the combinational PC+offset/link path into a parametrised block. It evaluates Thumb condition codes against NZCV, resolves immediate (PC-relative) and register (BX/BLX) targets, and produces a one-cycle PC-load and LR-write strobe. It then drives a counted pipeline flush window, during which new requests are blocked.

## Interface
- DATA_W, 32, datapath width of PC, offset, target and LR.
- FLUSH_CYCLES, 2, cycles of `flush` after a taken branch; legal range 1..15.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- br_valid  input  1  branch request strobe; accepted only when `busy`=0.
- br_type  input  2  00 unconditional B, 01 conditional B, 10 register BX, 11 reserved.
- link  input  1  write LR when the branch is taken (BL / BLX).
- cond  input  4  Thumb condition code; used only for br_type 01.
- nzcv  input  4  flags {N,Z,C,V} sampled at acceptance.
- offset  input  DATA_W  sign-extended byte offset for types 00/01.
- in_PC  input  DATA_W  PC value of the branch instruction as seen by execute.
- target  input  DATA_W  register operand for type 10.
- pc_load  output  1  one-cycle strobe: load `out_PC` into PC.
- out_PC  output  DATA_W  resolved target, valid while `pc_load`=1, else 0.
- lr_we  output  1  one-cycle strobe: write `LR`.
- LR  output  DATA_W  return address, valid while `lr_we`=1, else 0.
- flush  output  1  squash younger pipeline stages.
- busy  output  1  unit in flush window; `br_valid` ignored.
- bad_type  output  1  one-cycle strobe when a br_type 11 request is accepted.

## Operation
- Accept = br_valid & ~busy. All results are registered from inputs sampled at accept.
- The condition evaluates to true for types 00 and 10.
- For type 01, the condition follows the cond code:
  - 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V.
  - 1000 C&!Z, 1001 !C|Z, 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 Z|(N!=V).
  - 1110 true, 1111 false (never taken).
- Target for types 00/01: in_PC + offset, modulo 2^DATA_W; no overflow flag.
- Target for type 10: target with bit0 cleared. The Thumb bit is discarded.
- LR = in_PC with bit0 forced to 1. It is written only if link=1 and the branch is taken.
- link with type 01 is honoured.
- Type 11: no pc_load, no lr_we, no flush. bad_type pulses.
- States:
  - IDLE: on a taken accept, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - IDLE: on a not-taken or type-11 accept, stay in IDLE.
  - FLUSH: decrement cnt each cycle; return to IDLE when cnt=0 in that cycle.
- busy = flush = (state==FLUSH).
- Requests presented while busy are dropped, not queued. The upstream stage must hold or re-issue them.

## Timing
- Latency: a taken accept in cycle T produces pc_load/out_PC/lr_we/LR in T+1, each for exactly one cycle.
- flush/busy are high for cycles T+1 .. T+FLUSH_CYCLES inclusive. A new accept is possible at T+FLUSH_CYCLES+1.
- Not-taken accept at T: every output stays 0. A further accept is possible at T+1, back-to-back.
- bad_type is high at T+1 for one cycle.
- Reset values: pc_load=0, out_PC=0, lr_we=0, LR=0, flush=0, busy=0, bad_type=0, state=IDLE, cnt=0.
- Reset asserted mid-flush: all outputs are 0 in the cycle after the reset edge, and the window is abandoned.
- rst and br_valid in the same cycle: reset wins and the request is lost.
- nzcv changing during FLUSH has no effect; flags are sampled only at accept.

## Test plan
- Type 00, in_PC=0x0000_1000, offset=0xFFFF_FFF0, link=1 → T+1: pc_load=1, out_PC=0x0000_0FF0, lr_we=1, LR=0x0000_1001; flush high for 2 cycles.
- Type 01, cond=0000 with Z=0 → no strobes, busy=0. Next cycle, cond=0000 with Z=1 and offset=8 from in_PC=0x20 → out_PC=0x28.
- Sweep all 16 cond codes × 16 nzcv values → pc_load matches the condition table exactly; 1111 is never taken.
- Type 10, target=0x0000_2003, link=1, in_PC=0x0000_0100 → out_PC=0x0000_2002, LR=0x0000_0101.
- Taken branch, then br_valid held high through the flush window → the second request is ignored until T+3, then accepted. Repeat with FLUSH_CYCLES=1 and 4.
- Assert rst at T+1 of a taken branch → flush/busy=0 from T+2. A request with br_type=11 → bad_type for one cycle, no flush. Wrap case: in_PC=0xFFFF_FFFC, offset=8 → out_PC=0x0000_0004.
